// File: rtl/branch_pkg.sv
// Shared definitions for the execute-stage branch resolver: branch condition
// codes, the 2-bit bimodal counter type and its saturating update helpers.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_t;

    function automatic cnt_t cnt_inc(input cnt_t c);
        logic [1:0] n;
        n = c + 2'b01;
        return (c == ST) ? ST : cnt_t'(n);
    endfunction

    function automatic cnt_t cnt_dec(input cnt_t c);
        logic [1:0] n;
        n = c - 2'b01;
        return (c == SNT) ? SNT : cnt_t'(n);
    endfunction

    function automatic cnt_t cnt_update(input cnt_t c, input logic taken);
        return taken ? cnt_inc(c) : cnt_dec(c);
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Bimodal branch history table: array of 2-bit saturating counters with one
// combinational read port and one clocked update port (read-before-write).
module bht_2bit
    import branch_pkg::*;
#(
    parameter int          BHT_DEPTH = 64,
    parameter logic [1:0]  CNT_INIT  = 2'b01,
    localparam int         IDX_W     = $clog2(BHT_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    output cnt_t             rd_cnt_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    cnt_t cnt_q [BHT_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                cnt_q[i] <= cnt_t'(CNT_INIT);
            end
        end else if (upd_en_i) begin
            cnt_q[upd_idx_i] <= cnt_update(cnt_q[upd_idx_i], upd_taken_i);
        end
    end

    // Reads the registered array, so a same-cycle update is not visible yet.
    assign rd_cnt_o = cnt_q[rd_idx_i];

endmodule

// File: rtl/branch_resolve_bht.sv
// Execute-stage branch resolution: evaluates branch conditions and jump targets,
// issues a registered one-cycle redirect on mispredict, trains the BHT, counts events.
module branch_resolve_bht
    import branch_pkg::*;
#(
    parameter int         XLEN      = 32,
    parameter int         BHT_DEPTH = 64,
    parameter logic [1:0] CNT_INIT  = 2'b01,
    parameter int         PERF_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   if_pc,
    output logic              pred_taken,
    input  logic              ex_valid,
    input  logic              ex_branch,
    input  logic              ex_jal,
    input  logic              ex_jalr,
    input  logic [2:0]        ex_funct3,
    input  logic [XLEN-1:0]   ex_rs1,
    input  logic [XLEN-1:0]   ex_rs2,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic [XLEN-1:0]   ex_imm,
    input  logic              ex_pred_taken,
    output logic              redirect,
    output logic [XLEN-1:0]   redirect_pc,
    output logic [PERF_W-1:0] branch_cnt,
    output logic [PERF_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic              redirect_q,    redirect_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic [PERF_W-1:0] branch_cnt_q,  branch_cnt_d;
    logic [PERF_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic            eff_valid;
    logic            is_jalr, is_jal, is_br;
    logic            cond_taken;
    logic            train_en;
    logic [XLEN-1:0] br_target, jalr_sum, jalr_target, fall_through;
    cnt_t            rd_cnt;
    logic            unused_bits;

    bht_2bit #(
        .BHT_DEPTH (BHT_DEPTH),
        .CNT_INIT  (CNT_INIT)
    ) u_bht (
        .clk         (clk),
        .rst         (rst),
        .rd_idx_i    (if_pc[IDX_W+1:2]),
        .rd_cnt_o    (rd_cnt),
        .upd_en_i    (train_en),
        .upd_idx_i   (ex_pc[IDX_W+1:2]),
        .upd_taken_i (cond_taken)
    );

    assign pred_taken  = rd_cnt[1];
    assign unused_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0], rd_cnt[0]};

    always_comb begin
        cond_taken = 1'b0;
        unique case (ex_funct3)
            F3_BEQ:  cond_taken = (ex_rs1 == ex_rs2);
            F3_BNE:  cond_taken = (ex_rs1 != ex_rs2);
            F3_BLT:  cond_taken = ($signed(ex_rs1) <  $signed(ex_rs2));
            F3_BGE:  cond_taken = ($signed(ex_rs1) >= $signed(ex_rs2));
            F3_BLTU: cond_taken = (ex_rs1 <  ex_rs2);
            F3_BGEU: cond_taken = (ex_rs1 >= ex_rs2);
            default: cond_taken = 1'b0;
        endcase
    end

    always_comb begin
        // The instruction sitting in EX while a redirect is out is wrong-path.
        eff_valid    = ex_valid & ~redirect_q;
        is_jalr      = ex_jalr;
        is_jal       = ex_jal & ~ex_jalr;
        is_br        = ex_branch & ~ex_jal & ~ex_jalr;
        br_target    = ex_pc + ex_imm;
        jalr_sum     = ex_rs1 + ex_imm;
        jalr_target  = {jalr_sum[XLEN-1:1], 1'b0};
        fall_through = ex_pc + XLEN'(4);
        train_en     = eff_valid & is_br;

        redirect_d    = 1'b0;
        redirect_pc_d = '0;
        if (eff_valid) begin
            if (is_jalr) begin
                redirect_d    = 1'b1;
                redirect_pc_d = jalr_target;
            end else if (is_jal) begin
                redirect_d    = 1'b1;
                redirect_pc_d = br_target;
            end else if (is_br && (cond_taken != ex_pred_taken)) begin
                redirect_d    = 1'b1;
                redirect_pc_d = cond_taken ? br_target : fall_through;
            end
        end

        branch_cnt_d = branch_cnt_q;
        if (train_en && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + PERF_W'(1);
        end
        mispred_cnt_d = mispred_cnt_q;
        if (redirect_d && (mispred_cnt_q != '1)) begin
            mispred_cnt_d = mispred_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Randomised and directed bench for branch_resolve_bht against a behavioural
// model of the resolve/predict rules; expected per-cycle responses go through a queue.
module tb_branch_resolve_bht;

    localparam int XLEN  = 32;
    localparam int DEPTH = 64;
    localparam int PW    = 4;
    localparam int PMAX  = (1 << PW) - 1;
    localparam int EW    = 1 + XLEN + 2 * PW;

    logic            clk, rst;
    logic [XLEN-1:0] if_pc;
    logic            pred_taken;
    logic            ex_valid, ex_branch, ex_jal, ex_jalr;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_rs1, ex_rs2, ex_pc, ex_imm;
    logic            ex_pred_taken;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [PW-1:0]   branch_cnt, mispred_cnt;

    branch_resolve_bht #(
        .XLEN(XLEN), .BHT_DEPTH(DEPTH), .CNT_INIT(2'b01), .PERF_W(PW)
    ) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
        .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc),
        .ex_imm(ex_imm), .ex_pred_taken(ex_pred_taken), .redirect(redirect),
        .redirect_pc(redirect_pc), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];

    // behavioural model state
    int bht_m[DEPTH];
    int bcnt_m, mcnt_m;
    bit redir_prev_m;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) bht_m[i] = 1;
        bcnt_m = 0;
        mcnt_m = 0;
        redir_prev_m = 0;
    endtask

    task automatic drive_idle();
        ex_valid = 0; ex_branch = 0; ex_jal = 0; ex_jalr = 0; ex_funct3 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_pc = 0; ex_imm = 0; ex_pred_taken = 0;
    endtask

    // driver: one EX instruction per cycle, driven on the falling edge
    task automatic issue(input bit v, input bit br, input bit jal, input bit jalr,
                         input logic [2:0] f3, input logic [XLEN-1:0] rs1,
                         input logic [XLEN-1:0] rs2, input logic [XLEN-1:0] pc,
                         input logic [XLEN-1:0] imm, input bit pt,
                         input logic [XLEN-1:0] fpc);
        bit taken, redir, eff;
        logic [XLEN-1:0] target;
        int idx;
        @(negedge clk);
        ex_valid = v; ex_branch = br; ex_jal = jal; ex_jalr = jalr; ex_funct3 = f3;
        ex_rs1 = rs1; ex_rs2 = rs2; ex_pc = pc; ex_imm = imm; ex_pred_taken = pt;
        if_pc = fpc;
        #1;
        check("pred_taken", {31'b0, pred_taken}, {31'b0, bht_m[(fpc >> 2) % DEPTH] >= 2});

        eff = v && !redir_prev_m;
        case (f3)
            3'd0: taken = (rs1 == rs2);
            3'd1: taken = (rs1 != rs2);
            3'd4: taken = ($signed(rs1) < $signed(rs2));
            3'd5: taken = !($signed(rs1) < $signed(rs2));
            3'd6: taken = (rs1 < rs2);
            3'd7: taken = !(rs1 < rs2);
            default: taken = 0;
        endcase
        redir = 0;
        target = 0;
        if (jalr) begin
            redir = 1;
            target = (rs1 + imm) & ~32'h1;
        end else if (jal) begin
            redir = 1;
            target = pc + imm;
        end else if (br) begin
            redir = (taken != pt);
            target = taken ? pc + imm : pc + 32'd4;
            if (eff) begin
                idx = (pc >> 2) % DEPTH;
                bht_m[idx] = taken ? ((bht_m[idx] < 3) ? bht_m[idx] + 1 : 3)
                                   : ((bht_m[idx] > 0) ? bht_m[idx] - 1 : 0);
                bcnt_m = (bcnt_m < PMAX) ? bcnt_m + 1 : PMAX;
            end
        end
        redir = redir && eff;
        if (redir) mcnt_m = (mcnt_m < PMAX) ? mcnt_m + 1 : PMAX;
        redir_prev_m = redir;
        exp_q.push_back({redir, target, PW'(bcnt_m), PW'(mcnt_m)});
    endtask

    task automatic idle(input logic [XLEN-1:0] fpc);
        issue(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, fpc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        drive_idle();
        exp_q.delete();
        model_reset();
        #1;
        check("rst_redirect", {31'b0, redirect}, 32'h0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        check("rst_branch_cnt", {28'b0, branch_cnt}, 32'h0);
        check("rst_mispred_cnt", {28'b0, mispred_cnt}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    // monitor: compares the registered response one edge after each issue
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("redirect", {31'b0, redirect}, {31'b0, e[EW-1]});
                if (e[EW-1]) check("redirect_pc", redirect_pc, e[EW-2 -: XLEN]);
                check("branch_cnt", {28'b0, branch_cnt}, {28'b0, e[2*PW-1 -: PW]});
                check("mispred_cnt", {28'b0, mispred_cnt}, {28'b0, e[PW-1:0]});
            end
        end
    end

    task automatic random_run(input int n);
        bit v, br, jal, jalr, pt;
        logic [XLEN-1:0] rs1, rs2, pc, imm, fpc;
        for (int i = 0; i < n; i++) begin
            v    = ($urandom_range(0, 9) < 8);
            br   = ($urandom_range(0, 9) < 7);
            jal  = ($urandom_range(0, 9) == 0);
            jalr = ($urandom_range(0, 9) == 0);
            pt   = $urandom_range(0, 1);
            rs1  = $urandom;
            rs2  = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
            if ($urandom_range(0, 3) == 0) rs1 = {1'b1, rs1[30:0]};
            pc   = {$urandom_range(0, 255), 2'b00};
            imm  = $urandom;
            fpc  = ($urandom_range(0, 1) == 1) ? pc : {$urandom_range(0, 255), 2'b00};
            issue(v, br, jal, jalr, 3'($urandom_range(0, 7)), rs1, rs2, pc, imm, pt, fpc);
        end
    endtask

    initial begin
        rst = 1;
        if_pc = 0;
        drive_idle();
        model_reset();
        #1;
        check("init_redirect", {31'b0, redirect}, 32'h0);
        check("init_branch_cnt", {28'b0, branch_cnt}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 0;

        for (int w = 0; w < 64; w++) begin
            if_pc = w * 4;
            #1;
            check("sweep_pred", {31'b0, pred_taken}, 32'h0);
        end

        // taken BEQ predicted not-taken
        issue(1, 1, 0, 0, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 0, 32'h100);
        idle(32'h100);
        // signed vs unsigned on the same operands
        issue(1, 1, 0, 0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 0, 32'h200);
        idle(32'h200);
        issue(1, 1, 0, 0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h204, 32'h40, 1, 32'h204);
        idle(32'h204);
        issue(1, 1, 0, 0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h208, 32'h40, 0, 32'h208);
        // JALR with odd sum
        issue(1, 0, 0, 1, 3'b000, 32'h203, 32'h0, 32'h400, 32'h10, 0, 32'h400);
        idle(32'h400);
        // mispredict immediately followed by a valid JAL
        issue(1, 1, 0, 0, 3'b001, 32'd1, 32'd2, 32'h500, 32'h80, 0, 32'h500);
        issue(1, 0, 1, 0, 3'b000, 32'd0, 32'd0, 32'h504, 32'h100, 0, 32'h500);
        idle(32'h504);
        // saturate one entry
        for (int k = 0; k < 5; k++) begin
            issue(1, 1, 0, 0, 3'b000, 32'd7, 32'd7, 32'h300, 32'h40, 1, 32'h300);
            idle(32'h300);
        end
        // target wrap, and reserved funct3 counted but never redirected
        issue(1, 1, 0, 0, 3'b000, 32'd1, 32'd1, 32'hFFFF_FFFC, 32'h8, 0, 32'hFFFF_FFFC);
        idle(32'h0);
        issue(1, 1, 0, 0, 3'b010, 32'd1, 32'd1, 32'h600, 32'h8, 0, 32'h600);
        issue(1, 1, 0, 0, 3'b011, 32'd1, 32'd2, 32'h600, 32'h8, 0, 32'h600);
        idle(32'h600);
        // reset right after a redirect is registered
        issue(1, 0, 1, 0, 3'b000, 32'd0, 32'd0, 32'h700, 32'h44, 0, 32'h700);
        do_reset();

        random_run(1500);
        do_reset();
        random_run(600);
        idle(32'h0);
        @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
